// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the instruction/data SRAM port arbiter.
// Holds the FSM state, response owner and response record types plus the range check.
package mem_arb_pkg;

   typedef enum logic {
      ST_DPRI   = 1'b0,
      ST_IFORCE = 1'b1
   } arb_state_e;

   typedef enum logic {
      OWN_INSTR = 1'b0,
      OWN_DATA  = 1'b1
   } owner_e;

   typedef struct packed {
      logic   valid;
      owner_e owner;
      logic   err;
      logic   is_read;
   } rsp_info_t;

   localparam rsp_info_t RSP_IDLE = '{valid: 1'b0, owner: OWN_INSTR, err: 1'b0, is_read: 1'b0};

   // Widened to 64 bits so base + size cannot wrap for any 32-bit map.
   function automatic logic in_range(input logic [63:0] addr,
                                     input logic [63:0] base,
                                     input logic [63:0] size);
      return (addr >= base) && ((addr - base) < size);
   endfunction

endpackage

// File: rtl/mem_arb_starve_cnt.sv
// Saturating count of consecutive denied fetch cycles; flags the cycle it reaches LIMIT.
// limit_hit is taken from the next count so the override can take effect on the following cycle.
module mem_arb_starve_cnt #(
   parameter int unsigned LIMIT = 4,
   localparam int unsigned CW = $clog2(LIMIT + 1)
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic instr_req,
   input  logic instr_gnt,
   output logic limit_hit
);

   logic [CW-1:0] cnt_r;
   logic [CW-1:0] cnt_next_s;

   // Next count: grow while fetch waits, clear on grant or idle, hold at LIMIT.
   always_comb begin
      cnt_next_s = '0;
      if (instr_req && !instr_gnt) begin
         if (cnt_r == CW'(LIMIT)) begin
            cnt_next_s = cnt_r;
         end else begin
            cnt_next_s = cnt_r + CW'(1);
         end
      end else begin
         cnt_next_s = '0;
      end
   end

   assign limit_hit = (cnt_next_s == CW'(LIMIT));

   // Counter register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_r <= '0;
      end else begin
         cnt_r <= cnt_next_s;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one byte-enabled single-port SRAM between fetch and LSU ports with data priority
// and a starvation override for fetch. Optional perf counters: define ARB_PERF_CNT_EN.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned             ADDR_WIDTH   = 32,
   parameter int unsigned             DATA_WIDTH   = 32,
   parameter int unsigned             MEM_BYTES    = 16384,
   parameter logic [ADDR_WIDTH-1:0]   BASE_ADDR    = '0,
   parameter int unsigned             STARVE_LIMIT = 4,
   localparam int unsigned            BE_W         = DATA_WIDTH / 8,
   localparam int unsigned            MA_W         = $clog2(MEM_BYTES / 4)
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  instr_req_i,
   input  logic [ADDR_WIDTH-1:0] instr_addr_i,
   output logic                  instr_gnt_o,
   output logic                  instr_rvalid_o,
   output logic [DATA_WIDTH-1:0] instr_rdata_o,
   output logic                  instr_err_o,
   input  logic                  data_req_i,
   input  logic [ADDR_WIDTH-1:0] data_addr_i,
   input  logic                  data_we_i,
   input  logic [BE_W-1:0]       data_be_i,
   input  logic [DATA_WIDTH-1:0] data_wdata_i,
   output logic                  data_gnt_o,
   output logic                  data_rvalid_o,
   output logic [DATA_WIDTH-1:0] data_rdata_o,
   output logic                  data_err_o,
   output logic                  mem_en_o,
   output logic                  mem_we_o,
   output logic [BE_W-1:0]       mem_be_o,
   output logic [MA_W-1:0]       mem_addr_o,
   output logic [DATA_WIDTH-1:0] mem_wdata_o,
   input  logic [DATA_WIDTH-1:0] mem_rdata_i,
   output logic [31:0]           perf_conflict_o,
   output logic [31:0]           perf_override_o
);

   arb_state_e            state_r;
   arb_state_e            state_next_s;
   logic                  instr_win_s;
   logic                  data_win_s;
   logic                  starve_hit_s;
   logic [ADDR_WIDTH-1:0] sel_addr_s;
   logic [ADDR_WIDTH-1:0] offset_s;
   logic [MA_W-1:0]       word_addr_s;
   logic                  sel_in_range_s;
   rsp_info_t             rsp_r;
   rsp_info_t             rsp_next_s;

   mem_arb_starve_cnt #(
      .LIMIT (STARVE_LIMIT)
   ) u_starve (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .instr_req (instr_req_i),
      .instr_gnt (instr_win_s),
      .limit_hit (starve_hit_s)
   );

   // Grant selection and next state; grants are suppressed while reset is held.
   always_comb begin
      instr_win_s  = 1'b0;
      data_win_s   = 1'b0;
      state_next_s = state_r;
      if (!rst_ni) begin
         state_next_s = ST_DPRI;
      end else begin
         case (state_r)
            ST_DPRI: begin
               if (data_req_i) begin
                  data_win_s = 1'b1;
               end else if (instr_req_i) begin
                  instr_win_s = 1'b1;
               end else begin
                  instr_win_s = 1'b0;
               end
               if (starve_hit_s) begin
                  state_next_s = ST_IFORCE;
               end else begin
                  state_next_s = ST_DPRI;
               end
            end
            ST_IFORCE: begin
               // Either the forced grant happens now or fetch gave up; both end the override.
               if (instr_req_i) begin
                  instr_win_s = 1'b1;
               end else if (data_req_i) begin
                  data_win_s = 1'b1;
               end else begin
                  data_win_s = 1'b0;
               end
               state_next_s = ST_DPRI;
            end
            default: begin
               state_next_s = ST_DPRI;
            end
         endcase
      end
   end

   // FSM state register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_r <= ST_DPRI;
      end else begin
         state_r <= state_next_s;
      end
   end

   assign instr_gnt_o    = instr_win_s;
   assign data_gnt_o     = data_win_s;
   assign sel_addr_s     = instr_win_s ? instr_addr_i : data_addr_i;
   assign sel_in_range_s = in_range(64'(sel_addr_s), 64'(BASE_ADDR), 64'(MEM_BYTES));
   assign offset_s       = sel_addr_s - BASE_ADDR;
   assign word_addr_s    = MA_W'(offset_s >> 2);

   // SRAM command from the winning port; out-of-range grants never touch the array.
   always_comb begin
      mem_en_o    = 1'b0;
      mem_we_o    = 1'b0;
      mem_be_o    = '0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      if (instr_win_s) begin
         mem_en_o   = sel_in_range_s;
         mem_be_o   = '1;
         mem_addr_o = word_addr_s;
      end else if (data_win_s) begin
         mem_en_o    = sel_in_range_s;
         mem_we_o    = data_we_i && sel_in_range_s;
         mem_be_o    = data_be_i;
         mem_addr_o  = word_addr_s;
         mem_wdata_o = data_wdata_i;
      end else begin
         mem_en_o = 1'b0;
      end
   end

   // Response record for next cycle: reads and errored accesses answer, good writes stay silent.
   always_comb begin
      rsp_next_s = RSP_IDLE;
      if (instr_win_s) begin
         rsp_next_s = '{valid: 1'b1, owner: OWN_INSTR, err: !sel_in_range_s, is_read: 1'b1};
      end else if (data_win_s) begin
         rsp_next_s = '{valid:   !sel_in_range_s || !data_we_i,
                        owner:   OWN_DATA,
                        err:     !sel_in_range_s,
                        is_read: !data_we_i};
      end else begin
         rsp_next_s = RSP_IDLE;
      end
   end

   // Response record register; reset drops any response still in flight.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rsp_r <= RSP_IDLE;
      end else begin
         rsp_r <= rsp_next_s;
      end
   end

   assign instr_rvalid_o = rsp_r.valid && (rsp_r.owner == OWN_INSTR);
   assign data_rvalid_o  = rsp_r.valid && (rsp_r.owner == OWN_DATA);
   assign instr_err_o    = instr_rvalid_o && rsp_r.err;
   assign data_err_o     = data_rvalid_o && rsp_r.err;
   assign instr_rdata_o  = (instr_rvalid_o && rsp_r.is_read && !rsp_r.err) ? mem_rdata_i : '0;
   assign data_rdata_o   = (data_rvalid_o && rsp_r.is_read && !rsp_r.err) ? mem_rdata_i : '0;

`ifdef ARB_PERF_CNT_EN
   logic [31:0] conflict_r;
   logic [31:0] override_r;

   // Saturating event counters for contention and forced fetch grants.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         conflict_r <= 32'h0;
         override_r <= 32'h0;
      end else begin
         if (instr_req_i && data_req_i && (conflict_r != 32'hFFFF_FFFF)) begin
            conflict_r <= conflict_r + 32'd1;
         end else begin
            conflict_r <= conflict_r;
         end
         if (instr_win_s && (state_r == ST_IFORCE) && (override_r != 32'hFFFF_FFFF)) begin
            override_r <= override_r + 32'd1;
         end else begin
            override_r <= override_r;
         end
      end
   end

   assign perf_conflict_o = conflict_r;
   assign perf_override_o = override_r;
`else
   assign perf_conflict_o = 32'h0;
   assign perf_override_o = 32'h0;
`endif

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port, byte-enabled SRAM between the core's instruction-fetch port and data (LSU) port.
- Both requester ports use the core's req/gnt/rvalid protocol.
- Arbitration: fixed data-port priority, with a starvation override that guarantees fetch progress.
- Adds a range check and a per-port error response, and routes the 1-cycle-latency SRAM read data back to the granted requester.

Parameters:
- ADDR_WIDTH, 32, byte address width of both requester ports.
- DATA_WIDTH, 32, word width; byte enables are DATA_WIDTH/8 wide.
- MEM_BYTES, 16384, SRAM size in bytes; power of two.
- BASE_ADDR, 32'h0, byte address mapped to SRAM word 0.
- STARVE_LIMIT, 4, consecutive denied fetch cycles before fetch is forced to win.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- instr_req_i  in  1  fetch request
- instr_addr_i  in  ADDR_WIDTH  fetch byte address
- instr_gnt_o  out  1  fetch request accepted this cycle
- instr_rvalid_o  out  1  fetch response valid
- instr_rdata_o  out  DATA_WIDTH  fetch read data
- instr_err_o  out  1  fetch address out of range (qualified by rvalid)
- data_req_i  in  1  LSU request
- data_addr_i  in  ADDR_WIDTH  LSU byte address
- data_we_i  in  1  1 = write, 0 = read
- data_be_i  in  DATA_WIDTH/8  byte enables
- data_wdata_i  in  DATA_WIDTH  write data
- data_gnt_o  out  1  LSU request accepted
- data_rvalid_o  out  1  LSU response valid
- data_rdata_o  out  DATA_WIDTH  LSU read data
- data_err_o  out  1  LSU address out of range (qualified by rvalid)
- mem_en_o  out  1  SRAM access enable
- mem_we_o  out  1  SRAM write
- mem_be_o  out  DATA_WIDTH/8  SRAM byte enables
- mem_addr_o  out  $clog2(MEM_BYTES/4)  SRAM word address
- mem_wdata_o  out  DATA_WIDTH  SRAM write data
- mem_rdata_i  in  DATA_WIDTH  SRAM read data, valid the cycle after a read enable
- perf_conflict_o  out  32  cycles with both ports requesting
- perf_override_o  out  32  starvation-override grants

Behaviour:
- Reset values:
  - All gnt, rvalid, err, mem_en and mem_we outputs are 0; rdata outputs are 0.
  - Starvation counter is 0; state is ST_DPRI; response owner register is cleared.
- Grant logic is combinational from the current-cycle requests and state. At most one grant per cycle.
- FSM state ST_DPRI (normal operation):
  - If data_req_i is high, data is granted.
  - Otherwise, if instr_req_i is high, instr is granted.
- Starvation counter:
  - Increments each cycle instr_req_i is high and instr_gnt_o is low.
  - Clears on an instr grant or when instr_req_i is low.
  - Saturates at STARVE_LIMIT.
- FSM transitions:
  - ST_DPRI -> ST_IFORCE when the counter reaches STARVE_LIMIT.
  - In ST_IFORCE, instr is granted even if data_req_i is high.
  - ST_IFORCE -> ST_DPRI after that single grant, or immediately if instr_req_i drops.
- Range check: in range when BASE_ADDR <= addr < BASE_ADDR+MEM_BYTES.
  - In-range grant: mem_en_o=1; mem_addr_o=(addr-BASE_ADDR)>>2; address bits [1:0] ignored.
  - Out-of-range grant: still granted, mem_en_o=0, no SRAM access.
- mem_we/be/wdata are driven from the data port when data is granted. Fetches drive we=0, be=all-ones.
- Response pipeline:
  - A registered owner/valid/err/is_read record is captured on each grant.
  - Next cycle, the owner's rvalid is asserted for any read grant and for any out-of-range grant, reads and writes alike.
  - In-range writes produce no rvalid.
- Response data:
  - rdata = mem_rdata_i for in-range reads; 0 when err=1.
  - The non-owner port's rdata is held at 0.
- Throughput: back-to-back grants are allowed every cycle. Latency from gnt to rvalid is exactly 1 cycle.
- Requesters hold req/addr/we/be/wdata stable until granted. The arbiter does not latch ungranted requests.
- Reset mid-operation: any pending response is dropped; no rvalid is emitted after reset release for a pre-reset grant.

Optional Feature:
- Macro ARB_PERF_CNT_EN.
- Defined:
  - perf_conflict_o counts cycles with instr_req_i && data_req_i.
  - perf_override_o counts grants made in ST_IFORCE.
  - Both are 32-bit, saturate at all-ones, and reset to 0.
- Undefined: both outputs are tied to 0 and no counter flops are synthesised.

Decomposition:
- Shared package mem_arb_pkg holds:
  - typedef arb_state_e {ST_DPRI, ST_IFORCE};
  - typedef owner_e {OWN_INSTR, OWN_DATA};
  - struct rsp_info_t {valid, owner, err, is_read};
  - function in_range().
- One natural sub-module: mem_arb_starve_cnt (saturating counter plus limit compare), instantiated once.

Test Plan:
- Only instr_req_i=1 at addr 0x40 for 3 cycles -> each cycle: instr_gnt_o=1, mem_addr_o=0x10. Next cycle: instr_rvalid_o=1, instr_rdata_o=mem_rdata_i, instr_err_o=0.
- Both ports request continuously with STARVE_LIMIT=4 -> data granted cycles 0-3, instr granted cycle 4, then data again. Pattern repeats every 5 cycles; perf_override_o increments by 1 per period when ARB_PERF_CNT_EN is defined.
- Data write addr 0x100, be=4'b0011, wdata=0xA5A5_1234 -> mem_we_o=1, mem_be_o=4'b0011, mem_addr_o=0x40. No data_rvalid_o next cycle.
- Data read at 0x4000 with MEM_BYTES=16384 -> data_gnt_o=1, mem_en_o=0. Next cycle: data_rvalid_o=1, data_err_o=1, data_rdata_o=0.
- Grant data read, assert rst_ni=0 in the following cycle before its response -> data_rvalid_o=0 during and after reset, state is ST_DPRI, counter is 0.
- Alternating instr/data grants every cycle -> each rvalid appears only on the matching port one cycle later, and the other port's rdata stays 0.
